// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request and register-file writeback bundle for alu_seq.
interface alu_seq_if #(
    parameter int bw = 8,
    parameter int aw = 4
);
    logic          start;
    logic [2:0]    op;
    logic [bw-1:0] a;
    logic [bw-1:0] b;
    logic [aw-1:0] rd_in;
    logic [bw-1:0] d;
    logic [aw-1:0] rd;
    logic          writed;
    logic          busy;
    logic          zf;
    logic          cf;
    modport master(output start, op, a, b, rd_in, input d, rd, writed, busy, zf, cf);
    modport slave(input start, op, a, b, rd_in, output d, rd, writed, busy, zf, cf);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with registered writeback and flags.
// Define ALU_MUL_EN to include the bw-cycle shift-add multiplier for op 111.
module alu_seq #(
    parameter int bw = 8,
    parameter int aw = 4
) (
    input logic clk,
    input logic rst,
    alu_seq_if.slave bus
);
    localparam int sw = bw > 1 ? $clog2(bw) : 1;
`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
`else
    typedef enum logic [1:0] {IDLE, WB} state_t;
`endif
    state_t state;
    logic [bw:0] res;
    logic [sw-1:0] sh;
    assign sh = bus.b[sw-1:0];
    // res[bw] carries the flag: carry, borrow or last bit shifted out
    always_comb begin
        res = '0;
        case (bus.op)
            3'b000: res = {1'b0, bus.a} + {1'b0, bus.b};
            3'b001: res = {1'b0, bus.a} - {1'b0, bus.b};
            3'b010: res = {1'b0, bus.a & bus.b};
            3'b011: res = {1'b0, bus.a | bus.b};
            3'b100: res = {1'b0, bus.a ^ bus.b};
            3'b101: res = {1'b0, bus.a} << sh;
            3'b110: {res[bw-1:0], res[bw]} = {bus.a, 1'b0} >> sh;
            default: res = '0;
        endcase
    end
`ifdef ALU_MUL_EN
    logic [2*bw-1:0] p;
    logic [2*bw-1:0] pn;
    logic [bw-1:0]   mc;
    logic [sw-1:0]   cnt;
    logic [aw-1:0]   rd_q;
    logic [bw:0]     sum;
    // p holds {partial high, remaining multiplier}; shifted right every iteration
    assign sum = {1'b0, p[2*bw-1:bw]} + (p[0] ? {1'b0, mc} : '0);
    assign pn = {sum, p[bw-1:1]};
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            bus.d <= '0;
            bus.rd <= '0;
            bus.writed <= 1'b0;
            bus.busy <= 1'b0;
            bus.zf <= 1'b0;
            bus.cf <= 1'b0;
`ifdef ALU_MUL_EN
            p <= '0;
            mc <= '0;
            cnt <= '0;
            rd_q <= '0;
`endif
        end else begin
            bus.writed <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.op != 3'b111) begin
                        state <= WB;
                        bus.busy <= 1'b1;
                        bus.writed <= 1'b1;
                        bus.d <= res[bw-1:0];
                        bus.rd <= bus.rd_in;
                        bus.cf <= res[bw];
                        bus.zf <= res[bw-1:0] == '0;
                    end
`ifdef ALU_MUL_EN
                    else begin
                        state <= MUL;
                        bus.busy <= 1'b1;
                        mc <= bus.a;
                        p <= {{bw{1'b0}}, bus.b};
                        cnt <= '0;
                        rd_q <= bus.rd_in;
                    end
`endif
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    p <= pn;
                    cnt <= cnt + 1'b1;
                    if (cnt == sw'(bw - 1)) begin
                        state <= WB;
                        bus.writed <= 1'b1;
                        bus.d <= pn[bw-1:0];
                        bus.rd <= rd_q;
                        bus.cf <= |pn[2*bw-1:bw];
                        bus.zf <= pn[bw-1:0] == '0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand-written multi-cycle sequences for alu_seq.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    alu_seq_if #(.bw(8), .aw(4)) bus();
    alu_seq #(.bw(8), .aw(4)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] rd_in;
        logic [7:0] d;
        logic       cf;
        logic       zf;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] rdi);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.rd_in = rdi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h05, 4'd1, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 8'h03, 8'h05, 4'd2, 8'hFE, 1'b1, 1'b0};
        vecs[3]  = '{3'b101, 8'h81, 8'h01, 4'd4, 8'h02, 1'b1, 1'b0};
        vecs[4]  = '{3'b110, 8'h81, 8'h00, 4'd5, 8'h81, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 4'd6, 8'h30, 1'b0, 1'b0};
        vecs[6]  = '{3'b011, 8'h0F, 8'hF0, 4'd7, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 8'hAA, 8'hAA, 4'd8, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{3'b110, 8'h84, 8'h03, 4'd9, 8'h10, 1'b1, 1'b0};
        vecs[9]  = '{3'b101, 8'h03, 8'h0F, 4'd10, 8'h80, 1'b1, 1'b0};
        vecs[10] = '{3'b000, 8'h7F, 8'h01, 4'd11, 8'h80, 1'b0, 1'b0};
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.d, 4'(bus.rd), bus.writed, bus.busy, bus.zf, bus.cf}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd_in);
            chk($sformatf("v%0d_writed_busy", i), {bus.writed, bus.busy}, 2'b11);
            chk($sformatf("v%0d_d", i), bus.d, vecs[i].d);
            chk($sformatf("v%0d_rd", i), bus.rd, vecs[i].rd_in);
            chk($sformatf("v%0d_cf_zf", i), {bus.cf, bus.zf}, {vecs[i].cf, vecs[i].zf});
            step();
            chk($sformatf("v%0d_idle", i), {bus.writed, bus.busy, bus.d}, {2'b00, vecs[i].d});
        end

        // start held high through WB must not retrigger
        issue(3'b000, 8'h01, 8'h02, 4'd12);
        bus.start = 1'b1;
        chk("hold_wb_d", bus.d, 8'h03);
        step();
        bus.start = 1'b0;
        chk("hold_ignored_in_wb", {bus.writed, bus.busy}, 2'b00);
        repeat (3) step();
        chk("hold_d_rd", {bus.d, 4'(bus.rd)}, {8'h03, 4'd12});

`ifdef ALU_MUL_EN
        issue(3'b111, 8'd20, 8'd13, 4'd6);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                bus.start = 1'b1;
                bus.op = 3'b000;
                bus.a = 8'h11;
                bus.b = 8'h22;
                bus.rd_in = 4'd1;
            end
            if (i == 6) bus.start = 1'b0;
            chk($sformatf("mul_busy_%0d", i), {bus.writed, bus.busy}, 2'b01);
            if (i < 7) step();
        end
        step();
        chk("mul_wb", {bus.writed, bus.busy, bus.d, 4'(bus.rd), bus.cf, bus.zf}, {2'b11, 8'h04, 4'd6, 2'b10});
        step();
        chk("mul_done", {bus.writed, bus.busy}, 2'b00);
        repeat (3) step();
        chk("mul_no_extra_write", {bus.writed, bus.busy, bus.d}, {2'b00, 8'h04});

        issue(3'b111, 8'd20, 8'd13, 4'd7);
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_in_mul", {bus.d, 4'(bus.rd), bus.writed, bus.busy, bus.zf, bus.cf}, 32'h0);
`else
        issue(3'b000, 8'h05, 8'h06, 4'd7);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_in_wb", {bus.d, 4'(bus.rd), bus.writed, bus.busy, bus.zf, bus.cf}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("post_rst_quiet_%0d", i), {bus.writed, bus.busy}, 2'b00);
        end
        issue(3'b000, 8'd1, 8'd1, 4'd2);
        chk("post_rst_add", {bus.writed, bus.d, 4'(bus.rd), bus.cf, bus.zf}, {1'b1, 8'h02, 4'd2, 2'b00});
        step();

`ifndef ALU_MUL_EN
        issue(3'b001, 8'h03, 8'h05, 4'd9);
        step();
        issue(3'b111, 8'd20, 8'd13, 4'd3);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("nomul_%0d", i), {bus.writed, bus.busy, bus.d, 4'(bus.rd), bus.cf, bus.zf}, {2'b00, 8'hFE, 4'd9, 2'b10});
            step();
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
